// File: rtl/seq_pattern_tx_if.sv
// Bit-entry bundle between a pattern transmitter and a sequence detector.
// The master drives the control inputs; the slave drives the strobe and status.
interface seq_pattern_tx_if #(
    parameter int LEN   = 16,
    parameter int CNT_W = $clog2(LEN + 1)
) ();
    logic             start;
    logic             abort;
    logic [LEN-1:0]   pattern;
    logic [CNT_W-1:0] num_bits;
    logic             next;
    logic             in;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] bit_idx;

    modport master (
        output start, abort, pattern, num_bits,
        input  next, in, busy, done, bit_idx
    );

    modport slave (
        input  start, abort, pattern, num_bits,
        output next, in, busy, done, bit_idx
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Serialises a latched pattern LSB first onto a next/in strobe pair:
// per bit one setup cycle, PULSE_CYC strobe cycles, then GAP_CYC idle cycles.
module seq_pattern_tx #(
    parameter int LEN       = 16,
    parameter int PULSE_CYC = 2,
    parameter int GAP_CYC   = 25,
    localparam int CNT_W    = $clog2(LEN + 1)
) (
    input logic             clk,
    input logic             reset_n,
    seq_pattern_tx_if.slave bus
);

    localparam int MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_PULSE = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(LEN);
    localparam logic [CW-1:0]    PULSE_R = CW'(PULSE_CYC - 1);
    localparam logic [CW-1:0]    GAP_R   = CW'(GAP_CYC - 1);

    logic [2:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [LEN-1:0]   pat_q, pat_d;
    logic [CNT_W-1:0] num_q, num_d;
    logic             next_q, next_d;
    logic             in_q, in_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [CNT_W-1:0] clamp;
    logic [CNT_W-1:0] idx_inc;
    logic [LEN-1:0]   pat_sh;

    assign clamp   = (bus.num_bits > LEN_C) ? LEN_C : bus.num_bits;
    assign idx_inc = idx_q + CNT_W'(1);
    assign pat_sh  = pat_q >> idx_inc;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        pat_d   = pat_q;
        num_d   = num_q;
        next_d  = 1'b0;
        in_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;

        // Abort wins over every state transition; outputs fall to idle.
        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        pat_d = bus.pattern;
                        num_d = clamp;
                        idx_d = '0;
                        if (clamp == '0) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_SETUP;
                            busy_d  = 1'b1;
                            in_d    = bus.pattern[0];
                        end
                    end
                end
                S_SETUP: begin
                    state_d = S_PULSE;
                    cnt_d   = PULSE_R;
                    next_d  = 1'b1;
                    in_d    = in_q;
                    busy_d  = 1'b1;
                end
                S_PULSE: begin
                    busy_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = S_GAP;
                        cnt_d   = GAP_R;
                    end else begin
                        cnt_d  = cnt_q - CW'(1);
                        next_d = 1'b1;
                        in_d   = in_q;
                    end
                end
                S_GAP: begin
                    busy_d = 1'b1;
                    if (cnt_q == '0) begin
                        idx_d = idx_inc;
                        if (idx_inc == num_q) begin
                            state_d = S_DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d = S_SETUP;
                            in_d    = pat_sh[0];
                        end
                    end else begin
                        cnt_d = cnt_q - CW'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            pat_q   <= '0;
            num_q   <= '0;
            next_q  <= 1'b0;
            in_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            pat_q   <= pat_d;
            num_q   <= num_d;
            next_q  <= next_d;
            in_q    <= in_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.next    = next_q;
    assign bus.in      = in_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.bit_idx = idx_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Bench for seq_pattern_tx: vector table, randomized runs against a
// cycle-offset reference model, and hand-written abort/reset sequences.
module tb_seq_pattern_tx;

    localparam int LEN = 16;
    localparam int PC  = 2;
    localparam int GC  = 3;
    localparam int P   = 1 + PC + GC;

    logic clk = 1'b0;
    logic reset_n = 1'b0;

    seq_pattern_tx_if #(.LEN(LEN)) bus ();

    seq_pattern_tx #(
        .LEN      (LEN),
        .PULSE_CYC(PC),
        .GAP_CYC  (GC)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntotal = 0;

    typedef struct {
        logic [15:0] pat;
        logic [4:0]  num;
        int          exp_pulses;
        logic [15:0] exp_bits;
        int          exp_done_j;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endtask

    function automatic logic [8:0] outs();
        return {bus.next, bus.in, bus.busy, bus.done, bus.bit_idx};
    endfunction

    // Expected {next,in,busy,done,bit_idx} j edges after start was sampled.
    function automatic logic [8:0] model(input logic [15:0] pat,
                                         input int n, input int j);
        logic nx, ib, bz, dn;
        logic [4:0] ix;
        logic [15:0] s;
        int i, o;
        nx = 0; ib = 0; bz = 0; dn = 0; ix = 5'(n);
        if (j < n * P) begin
            i  = j / P;
            o  = j % P;
            s  = pat >> i;
            bz = 1'b1;
            ix = 5'(i);
            nx = (o >= 1 && o <= PC);
            ib = (o <= PC) ? s[0] : 1'b0;
        end else if (j == n * P) begin
            dn = 1'b1;
        end
        return {nx, ib, bz, dn, ix};
    endfunction

    function automatic logic [15:0] mask(input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return m[15:0];
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    task automatic run_tx(input logic [15:0] pat, input logic [4:0] num,
                          input bit rnd, output int pulses,
                          output logic [15:0] bits, output int done_j,
                          output int ndone);
        int n, total;
        logic prev;
        n = (int'(num) > LEN) ? LEN : int'(num);
        total = n * P;
        bus.start = 1'b1;
        bus.pattern = pat;
        bus.num_bits = num;
        @(posedge clk);
        pulses = 0; bits = '0; done_j = -1; ndone = 0; prev = 1'b0;
        for (int j = 0; j <= total + 1; j++) begin
            @(negedge clk);
            if (j == 0) bus.start = 1'b0;
            chk($sformatf("cyc pat=%h n=%0d j=%0d", pat, n, j),
                32'(outs()), 32'(model(pat, n, j)));
            if (bus.next && !prev) begin
                if (pulses < 16) bits[pulses[3:0]] = bus.in;
                pulses++;
            end
            prev = bus.next;
            if (bus.done) begin
                done_j = j;
                ndone++;
            end
            if (rnd && j < total) begin
                bus.start    = 1'($urandom);
                bus.pattern  = 16'($urandom);
                bus.num_bits = 5'($urandom);
            end else begin
                bus.start = 1'b0;
            end
        end
    endtask

    int pulses, done_j, ndone, cnt;
    logic [15:0] bits;
    logic [15:0] rp;
    logic [4:0] rn;
    int rnn;

    initial begin
        vecs[0] = '{16'h031A, 5'd11, 11, 16'h031A, 11 * P};
        vecs[1] = '{16'hFFFF, 5'd0,  0,  16'h0000, 0};
        vecs[2] = '{16'hFFFF, 5'd31, 16, 16'hFFFF, 16 * P};
        vecs[3] = '{16'hA5A5, 5'd16, 16, 16'hA5A5, 16 * P};
        vecs[4] = '{16'h0001, 5'd1,  1,  16'h0001, P};
        vecs[5] = '{16'h8001, 5'd17, 16, 16'h8001, 16 * P};

        bus.start = 1'b1;
        bus.abort = 1'b0;
        bus.pattern = 16'hFFFF;
        bus.num_bits = 5'd4;
        repeat (3) @(negedge clk);
        chk("reset outputs", 32'(outs()), 32'd0);
        bus.start = 1'b0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle after reset", 32'(outs()), 32'd0);

        foreach (vecs[v]) begin
            run_tx(vecs[v].pat, vecs[v].num, 1'b0, pulses, bits, done_j, ndone);
            chk($sformatf("vec%0d pulses", v), 32'(pulses), 32'(vecs[v].exp_pulses));
            chk($sformatf("vec%0d bits", v), 32'(bits), 32'(vecs[v].exp_bits));
            chk($sformatf("vec%0d done_j", v), 32'(done_j), 32'(vecs[v].exp_done_j));
        end

        for (int r = 0; r < 8; r++) begin
            rp = 16'($urandom);
            rn = 5'($urandom_range(0, 31));
            rnn = (int'(rn) > LEN) ? LEN : int'(rn);
            run_tx(rp, rn, 1'b1, pulses, bits, done_j, ndone);
            chk($sformatf("rnd%0d pulses", r), 32'(pulses), 32'(rnn));
            chk($sformatf("rnd%0d bits", r), 32'(bits), 32'(rp & mask(rnn)));
            chk($sformatf("rnd%0d ndone", r), 32'(ndone), 32'd1);
        end

        // Abort during the second strobe cycle of bit 3.
        bus.start = 1'b1;
        bus.pattern = 16'h00FF;
        bus.num_bits = 5'd8;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort pre next", 32'(bus.next), 32'd1);
        chk("abort pre idx", 32'(bus.bit_idx), 32'd3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort next/in/busy/done", 32'(outs() >> 5), 32'd0);
        ndone = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.done || bus.busy) ndone++;
        end
        chk("abort no done/busy", 32'(ndone), 32'd0);
        run_tx(16'h00FF, 5'd8, 1'b0, pulses, bits, done_j, ndone);
        chk("post-abort bits", 32'(bits), 32'h00FF);

        // Start together with abort in IDLE is dropped.
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.busy || bus.done || bus.next) cnt++;
        end
        chk("start+abort idle", 32'(cnt), 32'd0);

        // Asynchronous reset while strobing.
        bus.start = 1'b1;
        bus.pattern = 16'hFFFF;
        bus.num_bits = 5'd4;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        chk("pre-reset next", 32'(bus.next), 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("async reset next", 32'(bus.next), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.busy || bus.next || bus.done) cnt++;
        end
        chk("no resume after reset", 32'(cnt), 32'd0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
